xup_gate5_tester: RTL and testbench
===================================

# xup_gate5_tester

Exhaustive self-checking stimulus/response engine for the 5-input gate cells in the XUP library. It drives every input combination onto a gate under test, waits a programmable settle time, samples the gate output, and compares it against the expected truth table. Error count and first failing vector are reported for board-level lab checks or simulation benches.

## Interface

Parameters:
- `GATE_TYPE`, default 1: expected function.
  - 0 = AND, 1 = NAND, 2 = OR, 3 = NOR, 4 = XOR, 5 = XNOR.
  - Values 6–7 are treated as NAND.
- `SETTLE`, default 4: clock cycles each vector is held before `y` is sampled.
  - Legal range 1..255; 0 is illegal.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: begins a test run when sampled high in IDLE or DONE.
- `a`, `b`, `c`, `d`, `e` output 1 each: stimulus to the gate under test. `a` = vec[4] … `e` = vec[0].
- `y` input 1: gate-under-test output, sampled directly with no synchronizer.
- `busy` output 1: high while a run is in progress.
- `done` output 1: high from run completion until the next accepted start or reset.
- `pass` output 1: high with `done` when err_count == 0.
- `err_count` output 6: number of mismatching vectors, 0..32.
- `fail_seen` output 1: at least one mismatch recorded this run.
- `first_fail` output 5: vector index of the first mismatch; valid only when `fail_seen` = 1.

## Operation

- States:
  - IDLE: reset state.
  - RUN: vector applied, settle counter running.
  - DONE: results held.
- Reset (`reset_n` low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including `a`..`e`.
  - Vector register, settle counter, `err_count`, `first_fail` and `fail_seen` are all cleared.
- IDLE or DONE with `start` = 1:
  - Go to RUN, set vec = 0, counter = SETTLE-1.
  - Clear `err_count`, `fail_seen`, `first_fail`, `done`, `pass`.
  - Set `busy` = 1.
- RUN with counter ≠ 0: decrement the counter; `a`..`e` stay stable.
- RUN with counter = 0 (sample edge):
  - Compare `y` with f(vec), where f is selected by GATE_TYPE.
  - On mismatch: increment `err_count`. If `fail_seen` = 0, also set `fail_seen` = 1 and `first_fail` = vec.
  - If vec = 31: go to DONE, `busy` = 0, `done` = 1, `pass` = (final err_count == 0), and `a`..`e` return to 0.
  - Otherwise: vec = vec+1, counter = SETTLE-1.
- `start` while in RUN is ignored; the run is not restarted.
- DONE holds all results until `start` or reset.
- `err_count` cannot overflow: it is 6 bits and the maximum count is 32.
- `pass` must include the mismatch from the vector-31 sample taken on the same edge.
- Expected-value reference (vec = {a,b,c,d,e}):
  - AND = &vec; NAND = ~&vec
  - OR = |vec; NOR = ~|vec
  - XOR = ^vec; XNOR = ~^vec

## Timing

- Edge 0 is the edge at which `start` is accepted.
- Vector k is driven from edge k·SETTLE to edge (k+1)·SETTLE.
- Vector k is sampled at edge (k+1)·SETTLE; the next vector appears on that same edge.
- `done` rises at edge 32·SETTLE, so the run takes 32·SETTLE cycles.
  - SETTLE=4: 128 cycles.
- `y` must be stable before the sample edge. SETTLE·Tclk must exceed the gate DELAY plus wiring delay.
  - Example: 10 ns clock with a 3 ns gate needs SETTLE ≥ 1.
- All outputs are registered; there are no combinational paths from `y` or `start` to any output.
- A `start` held high continuously restarts on the first edge after DONE is entered. It never restarts mid-run.
- Reset asserted mid-run aborts immediately and asynchronously. After deassertion, a new `start` is required.

## Test plan

1. **Good NAND gate:** xup_nand5 (DELAY=3) on `a`..`e`/`y`, 10 ns clock, GATE_TYPE=1, SETTLE=1, pulse `start`.
   - Required: `done` at edge 32, `pass`=1, `err_count`=0, `fail_seen`=0, `busy` high for exactly 32 cycles.
2. **Stuck-at-1 output:** `y` tied 1, GATE_TYPE=1, SETTLE=4.
   - Required: `err_count`=1, `first_fail`=31, `pass`=0, `done` at edge 128.
3. **Stuck-at-0 output:** `y` tied 0, GATE_TYPE=1.
   - Required: `err_count`=31, `first_fail`=0.
   - Then rerun with GATE_TYPE=0 and `y` tied 0. Required: `err_count`=1, `first_fail`=31.
4. **Function mismatch:** good NAND gate attached, GATE_TYPE=0 (AND).
   - Required: `err_count`=32, `first_fail`=0, `pass`=0.
   - Also check the sequence {`a`..`e`} = 0,1,…,31, each held SETTLE cycles.
5. **Mid-run start and reset:**
   - Pulse `start` at vector 10. Required: ignored; vec continues to 11.
   - Assert `reset_n` low at vector 20. Required: `a`..`e`, `busy`, `done`, `err_count` go to 0 without waiting for a clock edge.
   - After release, `start` runs a full clean pass.
6. **XOR gate, held start:** XOR behavioral model, GATE_TYPE=4, `start` held high throughout.
   - Required: `pass`=1.
   - A second run begins the edge after DONE, with `done` cleared and `busy`=1 on that edge.

Source files
------------

// File: rtl/xup_gate5_tester.sv
//------------------------------------------------------------------------------
// Module  : xup_gate5_tester
// Brief   : Exhaustive stimulus/response checker for 5-input XUP gate cells.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module xup_gate5_tester #(
    parameter int GATE_TYPE = 1,
    parameter int SETTLE    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic       fail_seen,
    output logic [4:0] first_fail
);

    localparam logic [1:0] C_S_IDLE = 2'd0;
    localparam logic [1:0] C_S_RUN  = 2'd1;
    localparam logic [1:0] C_S_DONE = 2'd2;

    localparam logic [7:0] C_RELOAD   = 8'(SETTLE - 1);
    localparam logic [4:0] C_LAST_VEC = 5'd31;

    logic [1:0] r_state;
    logic [4:0] r_vec;
    logic [7:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [5:0] r_err_count;
    logic       r_fail_seen;
    logic [4:0] r_first_fail;

    logic       w_expected;
    logic       w_mismatch;
    logic [5:0] w_err_next;

    // Reference function fixed at elaboration; codes 6..7 fall back to NAND.
    generate
        if (GATE_TYPE == 0) begin : g_and
            assign w_expected = &r_vec;
        end else if (GATE_TYPE == 2) begin : g_or
            assign w_expected = |r_vec;
        end else if (GATE_TYPE == 3) begin : g_nor
            assign w_expected = ~|r_vec;
        end else if (GATE_TYPE == 4) begin : g_xor
            assign w_expected = ^r_vec;
        end else if (GATE_TYPE == 5) begin : g_xnor
            assign w_expected = ~^r_vec;
        end else begin : g_nand
            assign w_expected = ~&r_vec;
        end
    endgenerate

    assign w_mismatch = (y != w_expected);
    // Includes the current sample so pass reflects the vector-31 result.
    assign w_err_next = r_err_count + {5'd0, w_mismatch};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= C_S_IDLE;
            r_vec        <= 5'd0;
            r_cnt        <= 8'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= 6'd0;
            r_fail_seen  <= 1'b0;
            r_first_fail <= 5'd0;
        end else begin
            case (r_state)
                C_S_IDLE, C_S_DONE: begin
                    if (start) begin
                        r_state      <= C_S_RUN;
                        r_vec        <= 5'd0;
                        r_cnt        <= C_RELOAD;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err_count  <= 6'd0;
                        r_fail_seen  <= 1'b0;
                        r_first_fail <= 5'd0;
                    end
                end
                C_S_RUN: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        if (w_mismatch) begin
                            r_err_count <= w_err_next;
                            if (!r_fail_seen) begin
                                r_fail_seen  <= 1'b1;
                                r_first_fail <= r_vec;
                            end
                        end
                        if (r_vec == C_LAST_VEC) begin
                            r_state <= C_S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == 6'd0);
                            r_vec   <= 5'd0;
                        end else begin
                            r_vec <= r_vec + 5'd1;
                            r_cnt <= C_RELOAD;
                        end
                    end
                end
                default: begin
                    r_state <= C_S_IDLE;
                end
            endcase
        end
    end

    assign a          = r_vec[4];
    assign b          = r_vec[3];
    assign c          = r_vec[2];
    assign d          = r_vec[1];
    assign e          = r_vec[0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_seen  = r_fail_seen;
    assign first_fail = r_first_fail;

endmodule

`default_nettype wire

// File: tb/tb_xup_gate5_tester.sv
//------------------------------------------------------------------------------
// Module  : tb_xup_gate5_tester
// Brief   : Randomized fault-injection bench for xup_gate5_tester (NAND and XOR).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_xup_gate5_tester;

    localparam int c_settle0 = 2;
    localparam int c_type0   = 1;
    localparam int c_settle1 = 1;
    localparam int c_type1   = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic y0, y1;
    logic a0, b0, c0, d0, e0, busy0, done0, pass0, fs0;
    logic a1, b1, c1, d1, e1, busy1, done1, pass1, fs1;
    logic [5:0] err0, err1;
    logic [4:0] ff0, ff1;

    logic [4:0]  vec_o [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic        pass_o [2];
    logic        fs_o [2];
    logic [5:0]  err_o [2];
    logic [4:0]  ff_o [2];
    logic [31:0] fault_r [2];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xup_gate5_tester #(.GATE_TYPE(c_type0), .SETTLE(c_settle0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0),
        .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_seen(fs0), .first_fail(ff0)
    );

    xup_gate5_tester #(.GATE_TYPE(c_type1), .SETTLE(c_settle1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_seen(fs1), .first_fail(ff1)
    );

    assign vec_o[0]  = {a0, b0, c0, d0, e0};
    assign vec_o[1]  = {a1, b1, c1, d1, e1};
    assign busy_o[0] = busy0;
    assign busy_o[1] = busy1;
    assign done_o[0] = done0;
    assign done_o[1] = done1;
    assign pass_o[0] = pass0;
    assign pass_o[1] = pass1;
    assign fs_o[0]   = fs0;
    assign fs_o[1]   = fs1;
    assign err_o[0]  = err0;
    assign err_o[1]  = err1;
    assign ff_o[0]   = ff0;
    assign ff_o[1]   = ff1;

    // Truth tables from the count of high inputs.
    function automatic logic ref_gate(input int t, input logic [4:0] v);
        int ones;
        ones = $countones(v);
        case (t)
            0:       return ones == 5;
            2:       return ones > 0;
            3:       return ones == 0;
            4:       return (ones % 2) == 1;
            5:       return (ones % 2) == 0;
            default: return ones != 5;
        endcase
    endfunction

    // Gate under test: a good gate with a per-vector output inversion mask.
    always_comb begin
        y0 = ref_gate(c_type0, vec_o[0]) ^ fault_r[0][vec_o[0]];
        y1 = ref_gate(c_type1, vec_o[1]) ^ fault_r[1][vec_o[1]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_final(input int idx, input logic [31:0] fault);
        int first;
        first = 0;
        for (int i = 31; i >= 0; i--) if (fault[i]) first = i;
        chk("done", 32'(done_o[idx]), 32'd1);
        chk("busy_end", 32'(busy_o[idx]), 32'd0);
        chk("vec_end", 32'(vec_o[idx]), 32'd0);
        chk("pass", 32'(pass_o[idx]), 32'(fault == 32'd0));
        chk("err_count", 32'(err_o[idx]), 32'($countones(fault)));
        chk("fail_seen", 32'(fs_o[idx]), 32'(fault != 32'd0));
        if (fault != 32'd0) chk("first_fail", 32'(ff_o[idx]), 32'(first));
    endtask

    // Full run on dut0; optional start pulse in the middle of vector 10.
    task automatic run0(input logic [31:0] fault, input bit mid_start);
        fault_r[0] = fault;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int k = 0; k < 32 * c_settle0; k++) begin
            chk("vec", 32'(vec_o[0]), 32'(k / c_settle0));
            chk("busy", 32'(busy_o[0]), 32'd1);
            chk("done_low", 32'(done_o[0]), 32'd0);
            start0 = mid_start && (k == 10 * c_settle0);
            @(negedge clk);
        end
        start0 = 1'b0;
        check_final(0, fault);
    endtask

    initial begin
        logic [31:0] rnd;
        fault_r[0] = 32'd0;
        fault_r[1] = 32'd0;

        // Reset state
        #2;
        chk("rst_vec0", 32'(vec_o[0]), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_pass0", 32'(pass0), 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_fs0", 32'(fs0), 32'd0);
        chk("rst_ff0", 32'(ff0), 32'd0);
        chk("rst_vec1", 32'(vec_o[1]), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy0", 32'(busy0), 32'd0);

        // NAND: good gate, stuck patterns, last/first vector faults, random faults
        run0(32'h0000_0000, 1'b0);
        run0(32'hFFFF_FFFF, 1'b0);
        run0(32'h8000_0000, 1'b0);
        run0(32'h0000_0001, 1'b1);
        run0(32'h7FFF_FFFF, 1'b0);
        for (int r = 0; r < 3; r++) begin
            rnd = $urandom;
            run0(rnd, 1'b0);
        end

        // Asynchronous abort mid-run
        fault_r[0] = 32'hFFFF_FFFF;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (20 * c_settle0) @(negedge clk);
        chk("pre_rst_vec", 32'(vec_o[0]), 32'd20);
        chk("pre_rst_err", 32'(err0), 32'd20);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_vec", 32'(vec_o[0]), 32'd0);
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_done", 32'(done0), 32'd0);
        chk("arst_err", 32'(err0), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", 32'(busy0), 32'd0);
        run0(32'h0000_0000, 1'b0);

        // XOR with start held: back-to-back runs
        fault_r[1] = 32'd0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            chk("x_vec", 32'(vec_o[1]), 32'(k));
            chk("x_busy", 32'(busy1), 32'd1);
            @(negedge clk);
        end
        check_final(1, 32'd0);
        rnd = $urandom;
        fault_r[1] = rnd;
        @(negedge clk);
        chk("x_restart_done", 32'(done1), 32'd0);
        chk("x_restart_busy", 32'(busy1), 32'd1);
        start1 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk("x2_vec", 32'(vec_o[1]), 32'(k));
            @(negedge clk);
        end
        check_final(1, rnd);
        repeat (3) @(negedge clk);
        chk("x_hold_done", 32'(done1), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
